// File: rtl/hsv_core_fifo_lvl.sv
// Elastic FIFO between hsv_core pipeline stages. It uses all DEPTH entries, reports its occupancy and
// an almost_full watermark, and has a registered (FWFT=0) or fall-through (FWFT=1) output stage.
module hsv_core_fifo_lvl #(
    parameter int WIDTH        = 1,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1,
    parameter int FWFT         = 0
) (
    input  logic                       clk_core,
    input  logic                       rst_core,
    input  logic                       flush,
    output logic                       ready_o,
    input  logic                       valid_i,
    input  logic [WIDTH-1:0]           in,
    input  logic                       ready_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_full
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [LW-1:0] lvl_t;

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("hsv_core_fifo_lvl: WIDTH must be >= 1");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $error("hsv_core_fifo_lvl: DEPTH must be >= 2");
        end
        if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
            $error("hsv_core_fifo_lvl: AFULL_THRESH must be within 1..DEPTH");
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    lvl_t             level_q, level_d;
    lvl_t             mem_cnt;
    logic             valid_q, valid_d;
    logic             afull_q, afull_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] mem_rd_data;
    logic             wr_acc, rd_acc, mem_we, bypass;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o     = (level_q != lvl_t'(DEPTH));
    assign wr_acc      = valid_i & ready_o;
    assign rd_acc      = valid_q & ready_i;
    assign mem_rd_data = mem_q[rd_ptr_q];
    // level counts the beat in the output register; the remainder still sits in the array.
    assign mem_cnt     = level_q - lvl_t'(valid_q);

    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        valid_d  = valid_q;
        out_d    = out_q;
        mem_we   = 1'b0;
        bypass   = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            valid_d  = 1'b0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            // Refill the output stage whenever it is empty or being consumed.
            if (!valid_q || rd_acc) begin
                if (mem_cnt != '0) begin
                    valid_d  = 1'b1;
                    out_d    = mem_rd_data;
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                end else if (FWFT != 0 && wr_acc) begin
                    valid_d = 1'b1;
                    out_d   = in;
                    bypass  = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
            if (wr_acc && !bypass) begin
                mem_we   = 1'b1;
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
        end
        afull_d = (level_d >= lvl_t'(AFULL_THRESH));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            afull_q  <= 1'b0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            afull_q  <= afull_d;
            out_q    <= out_d;
        end
    end

    // NOTE: the storage array is deliberately left without reset; level and valid gate its use.
    always_ff @(posedge clk_core) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    assign valid_o     = valid_q;
    assign out         = out_q;
    assign level       = level_q;
    assign almost_full = afull_q;

endmodule

// File: tb/tb_hsv_core_fifo_lvl.sv
// Drives three FIFO configurations with shared stimulus and checks each against a queue-based model.
module tb_hsv_core_fifo_lvl;

    logic       clk_core = 1'b0;
    logic       rst_core;
    logic       flush;
    logic       valid_i;
    logic       ready_i;
    logic [7:0] din;

    logic       rdy  [3];
    logic       val  [3];
    logic       af   [3];
    logic [7:0] dout [3];
    logic [2:0] lvl0;
    logic [1:0] lvl1;
    logic [2:0] lvl2;

    always #5 clk_core = ~clk_core;

    hsv_core_fifo_lvl #(.WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .FWFT(0)) dut0 (
        .clk_core(clk_core), .rst_core(rst_core), .flush(flush), .ready_o(rdy[0]),
        .valid_i(valid_i), .in(din), .ready_i(ready_i), .valid_o(val[0]),
        .out(dout[0]), .level(lvl0), .almost_full(af[0]));

    hsv_core_fifo_lvl #(.WIDTH(8), .DEPTH(3), .AFULL_THRESH(2), .FWFT(0)) dut1 (
        .clk_core(clk_core), .rst_core(rst_core), .flush(flush), .ready_o(rdy[1]),
        .valid_i(valid_i), .in(din), .ready_i(ready_i), .valid_o(val[1]),
        .out(dout[1]), .level(lvl1), .almost_full(af[1]));

    hsv_core_fifo_lvl #(.WIDTH(8), .DEPTH(4), .AFULL_THRESH(4), .FWFT(1)) dut2 (
        .clk_core(clk_core), .rst_core(rst_core), .flush(flush), .ready_o(rdy[2]),
        .valid_i(valid_i), .in(din), .ready_i(ready_i), .valid_o(val[2]),
        .out(dout[2]), .level(lvl2), .almost_full(af[2]));

    // Reference: a queue of accepted beats tagged with the edge that wrote them.
    typedef struct packed {
        logic [7:0]  d;
        logic [31:0] wr;
    } beat_t;

    beat_t mq [3][$];
    int    md  [3] = '{4, 3, 4};
    int    mf  [3] = '{0, 0, 1};
    int    mth [3] = '{3, 2, 4};
    int    edge_cnt = 0;
    int    checks   = 0;
    int    failures = 0;

    function automatic int obs_lvl(input int i);
        case (i)
            0:       return int'(lvl0);
            1:       return int'(lvl1);
            default: return int'(lvl2);
        endcase
    endfunction

    // Head is visible at once in fall-through mode, one edge after its write otherwise.
    function automatic bit m_valid(input int i);
        if (mq[i].size() == 0) return 1'b0;
        if (mf[i] != 0) return 1'b1;
        return int'(mq[i][0].wr) < edge_cnt;
    endfunction

    task automatic compare_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            int exp_lvl;
            bit exp_val;
            exp_lvl = mq[i].size();
            exp_val = m_valid(i);
            checks++;
            if (obs_lvl(i) !== exp_lvl) begin
                failures++;
                $display("FAIL %s dut%0d level: got %0d expected %0d", tag, i, obs_lvl(i), exp_lvl);
            end
            checks++;
            if (rdy[i] !== (exp_lvl < md[i])) begin
                failures++;
                $display("FAIL %s dut%0d ready_o: got %b expected %b", tag, i, rdy[i], exp_lvl < md[i]);
            end
            checks++;
            if (af[i] !== (exp_lvl >= mth[i])) begin
                failures++;
                $display("FAIL %s dut%0d almost_full: got %b expected %b", tag, i, af[i], exp_lvl >= mth[i]);
            end
            checks++;
            if (val[i] !== exp_val) begin
                failures++;
                $display("FAIL %s dut%0d valid_o: got %b expected %b", tag, i, val[i], exp_val);
            end
            if (exp_val) begin
                checks++;
                if (dout[i] !== mq[i][0].d) begin
                    failures++;
                    $display("FAIL %s dut%0d out: got %h expected %h", tag, i, dout[i], mq[i][0].d);
                end
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit r, input bit f, input string tag);
        bit wr [3];
        bit rd [3];
        valid_i = v;
        din     = d;
        ready_i = r;
        flush   = f;
        for (int i = 0; i < 3; i++) begin
            wr[i] = v && (mq[i].size() < md[i]);
            rd[i] = m_valid(i) && r;
        end
        @(posedge clk_core);
        edge_cnt++;
        for (int i = 0; i < 3; i++) begin
            if (f) begin
                mq[i].delete();
            end else begin
                if (rd[i]) void'(mq[i].pop_front());
                if (wr[i]) mq[i].push_back('{d: d, wr: 32'(edge_cnt)});
            end
        end
        #1;
        compare_all(tag);
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_lvl(i) !== 0 || val[i] !== 1'b0 || af[i] !== 1'b0 || dout[i] !== 8'h00 || rdy[i] !== 1'b1) begin
                failures++;
                $display("FAIL %s dut%0d: got level=%0d valid=%b afull=%b out=%h ready=%b expected 0/0/0/00/1",
                         tag, i, obs_lvl(i), val[i], af[i], dout[i], rdy[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_core = 1'b1;
        valid_i  = 1'b1;
        din      = 8'hFF;
        ready_i  = 1'b1;
        flush    = 1'b0;
        repeat (3) @(posedge clk_core);
        edge_cnt += 3;
        #1;
        check_reset_values("reset");
        @(negedge clk_core);
        rst_core = 1'b0;
        valid_i  = 1'b0;
    endtask

    task automatic test_single_write();
        step(1'b1, 8'h11, 1'b1, 1'b0, "single_e1");
        checks++;
        if (val[0] !== 1'b0 || lvl0 !== 3'd1) begin
            failures++;
            $display("FAIL single_e1: got valid=%b level=%0d expected 0/1", val[0], lvl0);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, "single_e2");
        checks++;
        if (val[0] !== 1'b1 || dout[0] !== 8'h11 || lvl0 !== 3'd1) begin
            failures++;
            $display("FAIL single_e2: got valid=%b out=%h level=%0d expected 1/11/1", val[0], dout[0], lvl0);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, "single_e3");
        checks++;
        if (val[0] !== 1'b0 || lvl0 !== 3'd0) begin
            failures++;
            $display("FAIL single_e3: got valid=%b level=%0d expected 0/0", val[0], lvl0);
        end
    endtask

    task automatic test_fill_and_full_rw();
        logic [7:0] got [$];
        logic [7:0] exp_seq [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int k = 0; k < 5; k++) step(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0, "fill");
        checks++;
        if (lvl0 !== 3'd4 || rdy[0] !== 1'b0 || af[0] !== 1'b1) begin
            failures++;
            $display("FAIL fill_full: got level=%0d ready=%b afull=%b expected 4/0/1", lvl0, rdy[0], af[0]);
        end
        step(1'b1, 8'hA4, 1'b1, 1'b0, "full_rw");
        checks++;
        if (lvl0 !== 3'd3 || dout[0] !== 8'hA1 || val[0] !== 1'b1) begin
            failures++;
            $display("FAIL full_rw: got level=%0d out=%h valid=%b expected 3/A1/1", lvl0, dout[0], val[0]);
        end
        step(1'b1, 8'hA4, 1'b0, 1'b0, "full_rw_retry");
        checks++;
        if (lvl0 !== 3'd4) begin
            failures++;
            $display("FAIL full_rw_retry: got level=%0d expected 4", lvl0);
        end
        for (int k = 0; k < 8; k++) begin
            if (val[0] === 1'b1) got.push_back(dout[0]);
            step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        end
        checks++;
        if (got.size() != 4) begin
            failures++;
            $display("FAIL drain_count: got %0d beats expected 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got[k] !== exp_seq[k]) begin
                    failures++;
                    $display("FAIL drain_order[%0d]: got %h expected %h", k, got[k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got [$];
        int first_cyc = -1;
        int last_cyc  = -1;
        step(1'b0, 8'h00, 1'b1, 1'b1, "b2b_flush");
        for (int c = 0; c < 14; c++) begin
            if (c < 10) step(1'b1, 8'(c), 1'b1, 1'b0, "b2b");
            else step(1'b0, 8'h00, 1'b1, 1'b0, "b2b_tail");
            if (val[1] === 1'b1) begin
                got.push_back(dout[1]);
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
            end
        end
        checks++;
        if (got.size() != 10 || (last_cyc - first_cyc) != 9) begin
            failures++;
            $display("FAIL b2b_stream: got %0d beats over %0d cycles expected 10 over 10",
                     got.size(), last_cyc - first_cyc + 1);
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (got[k] !== 8'(k)) begin
                    failures++;
                    $display("FAIL b2b_order[%0d]: got %h expected %h", k, got[k], 8'(k));
                end
            end
        end
    endtask

    task automatic test_fwft_stall();
        step(1'b0, 8'h00, 1'b0, 1'b1, "fwft_flush");
        step(1'b1, 8'h5A, 1'b0, 1'b0, "fwft_write");
        checks++;
        if (val[2] !== 1'b1 || dout[2] !== 8'h5A) begin
            failures++;
            $display("FAIL fwft_latency: got valid=%b out=%h expected 1/5A", val[2], dout[2]);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, "fwft_stall");
            checks++;
            if (val[2] !== 1'b1 || dout[2] !== 8'h5A) begin
                failures++;
                $display("FAIL fwft_stall[%0d]: got valid=%b out=%h expected 1/5A", k, val[2], dout[2]);
            end
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, "fwft_consume");
        step(1'b0, 8'h00, 1'b1, 1'b0, "fwft_consume");
    endtask

    task automatic test_flush();
        step(1'b0, 8'h00, 1'b0, 1'b1, "flush_pre");
        step(1'b1, 8'h01, 1'b0, 1'b0, "flush_fill");
        step(1'b1, 8'h02, 1'b0, 1'b0, "flush_fill");
        checks++;
        if (lvl0 !== 3'd2) begin
            failures++;
            $display("FAIL flush_setup: got level=%0d expected 2", lvl0);
        end
        step(1'b1, 8'h77, 1'b1, 1'b1, "flush_edge");
        checks++;
        if (lvl0 !== 3'd0 || val[0] !== 1'b0 || rdy[0] !== 1'b1 || af[0] !== 1'b0) begin
            failures++;
            $display("FAIL flush_edge: got level=%0d valid=%b ready=%b afull=%b expected 0/0/1/0",
                     lvl0, val[0], rdy[0], af[0]);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "flush_after");
            checks++;
            if (val[0] !== 1'b0 || val[2] !== 1'b0) begin
                failures++;
                $display("FAIL flush_after[%0d]: got valid0=%b valid2=%b expected 0/0", k, val[0], val[2]);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0, "random");
        end
        for (int k = 0; k < 200; k++) begin
            step(($urandom % 4) == 0, 8'($urandom), ($urandom % 4) == 0, 1'b0, "random_press");
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 8'h31, 1'b0, 1'b0, "areset_fill");
        step(1'b1, 8'h32, 1'b0, 1'b0, "areset_fill");
        #2;
        rst_core = 1'b1;
        #1;
        check_reset_values("areset_immediate");
        for (int i = 0; i < 3; i++) mq[i].delete();
        valid_i = 1'b1;
        din     = 8'hEE;
        @(posedge clk_core);
        edge_cnt++;
        #1;
        check_reset_values("areset_held");
        @(negedge clk_core);
        rst_core = 1'b0;
        step(1'b1, 8'h44, 1'b1, 1'b0, "areset_after");
        step(1'b0, 8'h00, 1'b1, 1'b0, "areset_after");
        step(1'b0, 8'h00, 1'b1, 1'b0, "areset_after");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_and_full_rw();
        test_back_to_back();
        test_fwft_stall();
        test_flush();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
